delivery_collision_checker: RTL and testbench

- Consumer side of the delivery-game map. It reads the flattened obstacle and objective maps every time the map shifts.
- Checks the player's window rows in the player's lane. Raises one-cycle hit and collect pulses; keeps score and lives.
- Per-window "consumed" masks shift in lockstep with the map, so each map cell is acted on at most once.
- Sits between the map generator and the game FSM / display.

---
 rtl/delivery_pkg.sv | 20 ++
 rtl/delivery_window_mask.sv | 48 ++++
 rtl/delivery_collision_checker.sv | 196 +++++++++++++++++++
 tb/tb_delivery_collision_checker.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delivery_pkg.sv
// Shared definitions for the delivery-game collision checker: FSM encoding and
// default geometry / gameplay constants.
package delivery_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int DEF_LANES       = 4;
  localparam int DEF_WIN_LO      = 0;
  localparam int DEF_WIN_HI      = 7;
  localparam int DEF_START_LIVES = 3;
  localparam int COLLECT_MAX     = 7;
`ifdef DELIVERY_INVULN_EN
  localparam int DEF_INVULN_MOVES = 16;
`endif

endpackage

// File: rtl/delivery_window_mask.sv
// Per-cell "already consumed" flags for the player's window. Scrolls down one
// row with every map shift; a set in the same cycle uses the post-shift row.
module delivery_window_mask
  import delivery_pkg::*;
#(
  parameter int WIN    = 8,
  parameter int LANES  = DEF_LANES,
  parameter int ROW_W  = 3,
  parameter int LANE_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              shift,
  input  logic              set_en,
  input  logic [ROW_W-1:0]  set_row,
  input  logic [LANE_W-1:0] set_lane,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [LANE_W-1:0] rd_lane,
  output logic              rd_bit
);

  logic [WIN-1:0][LANES-1:0] mask;
  logic [WIN-1:0][LANES-1:0] mask_next;

  always_comb begin
    mask_next = mask;
    if (shift) begin
      for (int i = 0; i < WIN - 1; i++) begin
        mask_next[i] = mask[i + 1];
      end
      mask_next[WIN - 1] = '0;
    end
    if (set_en) begin
      mask_next[set_row][set_lane] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask <= '0;
    end else begin
      mask <= mask_next;
    end
  end

  assign rd_bit = mask[rd_row][rd_lane];

endmodule

// File: rtl/delivery_collision_checker.sv
// Scans the player's window rows in the player's lane after each map shift and
// reports hits/collects, keeping score and lives. Optional: DELIVERY_INVULN_EN.
module delivery_collision_checker
  import delivery_pkg::*;
#(
  parameter int ROWS        = 128,
  parameter int LANES       = DEF_LANES,
  parameter int WIN_LO      = DEF_WIN_LO,
  parameter int WIN_HI      = DEF_WIN_HI,
  parameter int SCORE_W     = 8,
  parameter int START_LIVES = DEF_START_LIVES
`ifdef DELIVERY_INVULN_EN
  ,
  parameter int INVULN_MOVES = DEF_INVULN_MOVES
`endif
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    move_map,
  input  logic [1:0]              player_lane,
  input  logic [ROWS*LANES-1:0]   map_obstacles_flat,
  input  logic [ROWS*LANES-1:0]   map_objectives_flat,
  output logic                    hit_pulse,
  output logic                    collect_pulse,
  output logic [2:0]              collect_count,
  output logic [SCORE_W-1:0]      score,
  output logic [2:0]              lives,
  output logic                    game_over,
  output logic                    busy
`ifdef DELIVERY_INVULN_EN
  ,
  output logic                    invulnerable
`endif
);

  localparam int WIN    = WIN_HI - WIN_LO + 1;
  localparam int ROW_W  = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int LANE_W = 2;
  localparam int IDX_W  = $clog2(ROWS * LANES);
  localparam int SUM_W  = SCORE_W + 1;

  function automatic logic [2:0] sat_inc_collect(input logic [2:0] v, input logic inc);
    return (inc && (v != 3'(COLLECT_MAX))) ? v + 3'd1 : v;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add_score(input logic [SCORE_W-1:0] s,
                                                       input logic [2:0] a);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, s} + SUM_W'(a);
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

  function automatic logic [2:0] sat_dec_lives(input logic [2:0] l, input logic dec);
    return (dec && (l != 3'd0)) ? l - 3'd1 : l;
  endfunction

  state_t            state;
  state_t            state_next;
  logic              scanning;
  logic              reporting;
  logic [ROW_W-1:0]  win_row;
  logic [ROW_W-1:0]  set_row;
  logic [LANE_W-1:0] scan_lane;
  logic              scan_hit;
  logic [2:0]        scan_collect;
  logic [IDX_W-1:0]  map_idx;
  logic              obs_cell;
  logic              obj_cell;
  logic              obs_seen;
  logic              obj_seen;
  logic              new_obs;
  logic              new_obj;
  logic              hit_now;
  logic              set_ok;
  logic              invuln_active;
  logic [2:0]        lives_after;
  logic              report_ends_game;

`ifdef DELIVERY_INVULN_EN
  localparam int INV_W = $clog2(INVULN_MOVES + 1);
  logic [INV_W-1:0] invuln_cnt;

  // A fresh hit reloads the window even if a move lands on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      invuln_cnt <= '0;
    end else if (reporting && scan_hit) begin
      invuln_cnt <= INV_W'(INVULN_MOVES);
    end else if (move_map && (invuln_cnt != '0)) begin
      invuln_cnt <= invuln_cnt - INV_W'(1);
    end
  end

  assign invuln_active = (invuln_cnt != '0);
  assign invulnerable  = invuln_active;
`else
  assign invuln_active = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (move_map && !game_over) state_next = SCAN;
      SCAN:    if (!move_map && (win_row == '0)) state_next = REPORT;
      REPORT:  state_next = (move_map && !report_ends_game) ? SCAN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    scanning  = (state == SCAN);
    reporting = (state == REPORT);
  end

  // Cell under inspection; a same-cycle shift moves it one row down in the mask.
  always_comb begin
    map_idx  = IDX_W'((WIN_LO + int'(win_row)) * LANES + int'(scan_lane));
    obs_cell = map_obstacles_flat[map_idx];
    obj_cell = map_objectives_flat[map_idx];
    new_obs  = scanning && obs_cell && !obs_seen;
    new_obj  = scanning && obj_cell && !obj_seen;
    hit_now  = new_obs && !invuln_active;
    set_ok   = !move_map || (win_row != '0);
    set_row  = move_map ? win_row - ROW_W'(1) : win_row;
  end

  assign lives_after      = sat_dec_lives(lives, scan_hit);
  assign report_ends_game = (lives_after == 3'd0);
  assign game_over        = (lives == 3'd0);

  delivery_window_mask #(
    .WIN(WIN), .LANES(LANES), .ROW_W(ROW_W), .LANE_W(LANE_W)
  ) u_obstacle_mask (
    .clock(clock), .reset(reset), .shift(move_map),
    .set_en(new_obs && set_ok), .set_row(set_row), .set_lane(scan_lane),
    .rd_row(win_row), .rd_lane(scan_lane), .rd_bit(obs_seen)
  );

  delivery_window_mask #(
    .WIN(WIN), .LANES(LANES), .ROW_W(ROW_W), .LANE_W(LANE_W)
  ) u_objective_mask (
    .clock(clock), .reset(reset), .shift(move_map),
    .set_en(new_obj && set_ok), .set_row(set_row), .set_lane(scan_lane),
    .rd_row(win_row), .rd_lane(scan_lane), .rd_bit(obj_seen)
  );

  // Scan bookkeeping: a move mid-scan restarts the rows but keeps the tallies.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      win_row      <= '0;
      scan_lane    <= '0;
      scan_hit     <= 1'b0;
      scan_collect <= '0;
    end else if (scanning) begin
      scan_hit     <= scan_hit | hit_now;
      scan_collect <= sat_inc_collect(scan_collect, new_obj);
      win_row      <= move_map ? ROW_W'(WIN - 1) : win_row - ROW_W'(1);
      if (move_map) begin
        scan_lane <= player_lane;
      end
    end else if (state_next == SCAN) begin
      scan_hit     <= 1'b0;
      scan_collect <= '0;
      win_row      <= ROW_W'(WIN - 1);
      scan_lane    <= player_lane;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_pulse     <= 1'b0;
      collect_pulse <= 1'b0;
      collect_count <= '0;
      score         <= '0;
      lives         <= 3'(START_LIVES);
    end else begin
      hit_pulse     <= reporting && scan_hit;
      collect_pulse <= reporting && (scan_collect != 3'd0);
      collect_count <= reporting ? scan_collect : 3'd0;
      if (reporting) begin
        score <= sat_add_score(score, scan_collect);
        lives <= lives_after;
      end
    end
  end

endmodule

// File: tb/tb_delivery_collision_checker.sv
// Randomised and directed bench for delivery_collision_checker against a
// map-level behavioural model with whole-map consumed flags.
`timescale 1ns/1ps
module tb_delivery_collision_checker;
  import delivery_pkg::*;

  localparam int ROWS         = 128;
  localparam int LANES        = 4;
  localparam int WIN_LO       = 0;
  localparam int WIN_HI       = 7;
  localparam int WIN          = WIN_HI - WIN_LO + 1;
  localparam int SCORE_W      = 8;
  localparam int SCORE_MAX    = (1 << SCORE_W) - 1;
  localparam int START_LIVES  = 3;
  localparam int INVULN_MOVES = 16;
  localparam int FLAT_W       = ROWS * LANES;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               move_map = 1'b0;
  logic [1:0]         player_lane = 2'd0;
  logic [FLAT_W-1:0]  obs_flat = '0;
  logic [FLAT_W-1:0]  obj_flat = '0;
  logic               hit_pulse;
  logic               collect_pulse;
  logic [2:0]         collect_count;
  logic [SCORE_W-1:0] score;
  logic [2:0]         lives;
  logic               game_over;
  logic               busy;
`ifdef DELIVERY_INVULN_EN
  logic               invulnerable;
`endif

  always #5 clock = ~clock;

  delivery_collision_checker dut (
    .clock(clock), .reset(reset), .move_map(move_map), .player_lane(player_lane),
    .map_obstacles_flat(obs_flat), .map_objectives_flat(obj_flat),
    .hit_pulse(hit_pulse), .collect_pulse(collect_pulse), .collect_count(collect_count),
    .score(score), .lives(lives), .game_over(game_over), .busy(busy)
`ifdef DELIVERY_INVULN_EN
    , .invulnerable(invulnerable)
`endif
  );

  // Bench-side map and model state
  logic [LANES-1:0] map_obs [ROWS];
  logic [LANES-1:0] map_obj [ROWS];
  logic [LANES-1:0] used_obs [ROWS];
  logic [LANES-1:0] used_obj [ROWS];
  bit m_scan, m_rep, m_acc_hit, m_hit_pulse, m_col_pulse;
  int m_row, m_lane, m_acc_cnt, m_score, m_lives, m_inv, m_cc;

  int errors = 0, checks = 0, edge_cnt = 0;
  int hit_seen = 0, col_seen = 0, last_hit_edge = -1, last_cc = -1;
  bit checking = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic void drive_flats();
    for (int r = 0; r < ROWS; r++) begin
      obs_flat[r*LANES +: LANES] = map_obs[r];
      obj_flat[r*LANES +: LANES] = map_obj[r];
    end
  endfunction

  function automatic void clear_map();
    for (int r = 0; r < ROWS; r++) begin
      map_obs[r] = '0;
      map_obj[r] = '0;
    end
    drive_flats();
  endfunction

  function automatic void model_reset();
    m_scan = 0; m_rep = 0; m_acc_hit = 0; m_acc_cnt = 0; m_row = 0; m_lane = 0;
    m_score = 0; m_lives = START_LIVES; m_inv = 0;
    m_hit_pulse = 0; m_col_pulse = 0; m_cc = 0;
    for (int r = 0; r < ROWS; r++) begin
      used_obs[r] = '0;
      used_obj[r] = '0;
    end
  endfunction

  function automatic void shift_map(input logic [LANES-1:0] t_obs, input logic [LANES-1:0] t_obj);
    for (int r = 0; r < ROWS - 1; r++) begin
      map_obs[r]  = map_obs[r + 1];
      map_obj[r]  = map_obj[r + 1];
      used_obs[r] = used_obs[r + 1];
      used_obj[r] = used_obj[r + 1];
    end
    map_obs[ROWS-1]  = t_obs;
    map_obj[ROWS-1]  = t_obj;
    used_obs[ROWS-1] = '0;
    used_obj[ROWS-1] = '0;
  endfunction

  // One clock edge of game behaviour, seen from the map's point of view.
  function automatic void model_edge(input bit mv, input int pl);
    bit was_scan = m_scan;
    bit was_rep  = m_rep;
    int inv_now  = m_inv;
    bit nscan = 0, nrep = 0;
    m_hit_pulse = 0; m_col_pulse = 0; m_cc = 0;
    if (was_scan) begin
      if (map_obs[m_row][m_lane] && !used_obs[m_row][m_lane]) begin
        used_obs[m_row][m_lane] = 1'b1;
        if (inv_now == 0) m_acc_hit = 1;
      end
      if (map_obj[m_row][m_lane] && !used_obj[m_row][m_lane]) begin
        used_obj[m_row][m_lane] = 1'b1;
        if (m_acc_cnt < 7) m_acc_cnt++;
      end
      if (mv) begin nscan = 1; m_row = WIN_HI; m_lane = pl; end
      else if (m_row == WIN_LO) nrep = 1;
      else begin nscan = 1; m_row--; end
    end
    if (was_rep) begin
      m_hit_pulse = m_acc_hit;
      m_col_pulse = (m_acc_cnt != 0);
      m_cc        = m_acc_cnt;
      m_score     = (m_score + m_acc_cnt > SCORE_MAX) ? SCORE_MAX : m_score + m_acc_cnt;
      if (m_acc_hit && m_lives > 0) m_lives--;
    end
`ifdef DELIVERY_INVULN_EN
    if (was_rep && m_acc_hit) m_inv = INVULN_MOVES;
    else if (mv && m_inv > 0) m_inv--;
`endif
    if (!was_scan && mv && m_lives != 0) begin
      nscan = 1; m_row = WIN_HI; m_lane = pl; m_acc_hit = 0; m_acc_cnt = 0;
    end
    m_scan = nscan;
    m_rep  = nrep;
  endfunction

  task automatic cyc(input bit mv, input logic [1:0] pl,
                     input logic [LANES-1:0] t_obs, input logic [LANES-1:0] t_obj);
    move_map = mv;
    player_lane = pl;
    @(posedge clock);
    #1;
    edge_cnt++;
    if (!reset) model_edge(mv, int'(pl));
    if (mv) shift_map(t_obs, t_obj);
    drive_flats();
    move_map = 1'b0;
  endtask

  task automatic move_idle(input logic [1:0] pl, input logic [LANES-1:0] t_obs,
                           input logic [LANES-1:0] t_obj, input int gap);
    cyc(1'b1, pl, t_obs, t_obj);
    repeat (gap) cyc(1'b0, pl, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    cyc(1'b0, 2'd0, '0, '0);
    cyc(1'b0, 2'd0, '0, '0);
    reset = 1'b0;
    cyc(1'b0, 2'd0, '0, '0);
  endtask

  always @(negedge clock) begin
    if (checking) begin
      check("hit_pulse", int'(hit_pulse), int'(m_hit_pulse));
      check("collect_pulse", int'(collect_pulse), int'(m_col_pulse));
      check("collect_count", int'(collect_count), m_cc);
      check("score", int'(score), m_score);
      check("lives", int'(lives), m_lives);
      check("game_over", int'(game_over), int'(m_lives == 0));
      check("busy", int'(busy), int'(m_scan || m_rep));
`ifdef DELIVERY_INVULN_EN
      check("invulnerable", int'(invulnerable), int'(m_inv != 0));
`endif
      if (hit_pulse) begin hit_seen++; last_hit_edge = edge_cnt; end
      if (collect_pulse) begin col_seen++; last_cc = int'(collect_count); end
    end
  end

  initial begin
    int h0, c0, e2, mv_rate;
    bit mv;
    logic [1:0] pl;
    logic [LANES-1:0] to, tj;
    clear_map();
    model_reset();
    checking = 1'b1;
    do_reset();

    check("reset_lives", int'(lives), 3);
    check("reset_score", int'(score), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_game_over", int'(game_over), 0);

    // Single obstacle in the player's lane: exactly one hit.
    clear_map(); do_reset(); h0 = hit_seen;
    for (int i = 0; i < 130; i++) move_idle(2'd2, (i == 0) ? 4'b0100 : 4'b0000, '0, 10);
    check("obstacle_hits", hit_seen - h0, 1);
    check("obstacle_lives", int'(lives), 2);

    // Single objective in the player's lane: one collect, never twice.
    clear_map(); do_reset(); c0 = col_seen;
    for (int i = 0; i < 130; i++) move_idle(2'd1, '0, (i == 0) ? 4'b0010 : 4'b0000, 10);
    check("objective_collects", col_seen - c0, 1);
    check("objective_count", last_cc, 1);
    check("objective_score", int'(score), 1);

    // Obstacle in another lane never hits.
    clear_map(); do_reset(); h0 = hit_seen;
    for (int i = 0; i < 130; i++) move_idle(2'd0, (i == 0) ? 4'b1000 : 4'b0000, '0, 10);
    check("other_lane_hits", hit_seen - h0, 0);
    check("other_lane_lives", int'(lives), 3);

    // Three hits end the game; the fourth obstacle and its objective are ignored.
    clear_map(); do_reset(); h0 = hit_seen;
    for (int i = 0; i < 200; i++)
      move_idle(2'd2, (i % 20 == 0 && i <= 60) ? 4'b0100 : 4'b0000,
                (i == 60) ? 4'b0100 : 4'b0000, 10);
    check("gameover_hits", hit_seen - h0, 3);
    check("gameover_lives", int'(lives), 0);
    check("gameover_flag", int'(game_over), 1);
    check("gameover_score", int'(score), 0);
    cyc(1'b1, 2'd2, '0, '0);
    check("gameover_busy", int'(busy), 0);

    // Move at scan cycle 4 restarts the scan; one report WIN+1 edges later.
    clear_map(); do_reset();
    for (int i = 0; i < 120; i++) move_idle(2'd2, (i == 0) ? 4'b0100 : 4'b0000, '0, 10);
    h0 = hit_seen;
    cyc(1'b1, 2'd2, '0, '0);
    repeat (3) cyc(1'b0, 2'd2, '0, '0);
    cyc(1'b1, 2'd2, '0, '0);
    e2 = edge_cnt;
    repeat (14) cyc(1'b0, 2'd2, '0, '0);
    check("restart_hits", hit_seen - h0, 1);
    check("restart_latency", last_hit_edge - e2, WIN + 1);

`ifdef DELIVERY_INVULN_EN
    clear_map(); do_reset(); h0 = hit_seen;
    for (int i = 0; i < 160; i++) begin
      move_idle(2'd2, (i == 0 || i == 10 || i == 30) ? 4'b0100 : 4'b0000, '0, 10);
      if (i == 130) check("invuln_window", int'(invulnerable), 1);
    end
    check("invuln_hits", hit_seen - h0, 2);
    check("invuln_lives", int'(lives), 1);
`endif

    // Full objective field: first scan saturates the per-scan count, score saturates.
    for (int r = 0; r < ROWS; r++) begin map_obs[r] = '0; map_obj[r] = '1; end
    drive_flats(); do_reset();
    for (int i = 0; i < 270; i++) begin
      move_idle(2'($urandom_range(0, 3)), '0, '1, 8);
      if (i == 1) check("collect_saturate", last_cc, 7);
    end
    repeat (12) cyc(1'b0, 2'd0, '0, '0);
    check("score_saturate", int'(score), SCORE_MAX);

    // Randomised play with occasional resets, including mid-scan.
    clear_map(); do_reset(); mv_rate = 4;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) mv_rate = $urandom_range(1, 12);
      mv = ($urandom_range(0, mv_rate) == 0);
      pl = 2'($urandom_range(0, 3));
      for (int b = 0; b < LANES; b++) begin
        to[b] = ($urandom_range(0, 9) == 0);
        tj[b] = ($urandom_range(0, 3) == 0);
      end
      if ((m_lives == 0 && $urandom_range(0, 30) == 0) || $urandom_range(0, 600) == 0) do_reset();
      else cyc(mv, pl, to, tj);
    end

    repeat (2) @(posedge clock);
    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
